// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the Execute stage: restoring radix-2 division,
// shift-add multiply, or single-cycle multiply when MULDIV_FAST_MUL_EN is defined.
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            MulDivE,
    input  logic [2:0]      funct3E,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic            FlushE,
    output logic            StallMD,
    output logic            DoneMD,
    output logic [XLEN-1:0] ResultMD
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [4:0]      LAST    = 5'(XLEN - 1);

    state_t          state_q, state_d;
    logic [4:0]      count_q, count_d;
    logic [XLEN-1:0] hi_q, hi_d;       // partial product high half / partial remainder
    logic [XLEN-1:0] lo_q, lo_d;       // multiplier / dividend shifting into quotient
    logic [XLEN-1:0] m_q, m_d;         // |multiplicand| or |divisor|
    logic [2:0]      op_q, op_d;
    logic            neg_q, neg_d;     // operand signs differ
    logic            rem_neg_q, rem_neg_d;
    logic [XLEN-1:0] result_q, result_d;

    // Operand decode in IDLE
    logic            a_signed, b_signed, sign_a, sign_b;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            div_zero, div_ovf;

    assign a_signed = (funct3E == 3'b001) || (funct3E == 3'b010) ||
                      (funct3E == 3'b100) || (funct3E == 3'b110);
    assign b_signed = (funct3E == 3'b001) || (funct3E == 3'b100) || (funct3E == 3'b110);
    assign sign_a   = a_signed & SrcAE[XLEN-1];
    assign sign_b   = b_signed & SrcBE[XLEN-1];
    assign abs_a    = sign_a ? -SrcAE : SrcAE;
    assign abs_b    = sign_b ? -SrcBE : SrcBE;
    assign div_zero = funct3E[2] && (SrcBE == '0);
    assign div_ovf  = funct3E[2] && !funct3E[0] && (SrcAE == INT_MIN) && (SrcBE == '1);

    // One restoring-division step
    logic [XLEN:0]   div_shift;
    logic [XLEN+1:0] div_diff;
    logic            div_ok;
    logic [XLEN-1:0] div_hi, div_lo;

    assign div_shift = {hi_q, lo_q[XLEN-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, m_q};
    assign div_ok    = ~div_diff[XLEN+1];
    assign div_hi    = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    assign div_lo    = {lo_q[XLEN-2:0], div_ok};

    logic [XLEN-1:0] iter_hi, iter_lo;

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fa, fb;
    logic        [2*XLEN-1:0] fprod;
    logic        [XLEN-1:0]   fast_res;

    assign fa       = {sign_a, SrcAE};
    assign fb       = {sign_b, SrcBE};
    // Sign-extended operands make the low 2*XLEN bits of the unsigned product the signed product
    assign fprod    = {{(XLEN-1){fa[XLEN]}}, fa} * {{(XLEN-1){fb[XLEN]}}, fb};
    assign fast_res = (funct3E[1:0] == 2'b00) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
    assign iter_hi  = div_hi;
    assign iter_lo  = div_lo;
`else
    logic [XLEN:0] mul_add;

    assign mul_add = lo_q[0] ? ({1'b0, hi_q} + {1'b0, m_q}) : {1'b0, hi_q};
    assign iter_hi = op_q[2] ? div_hi : mul_add[XLEN:1];
    assign iter_lo = op_q[2] ? div_lo : {mul_add[0], lo_q[XLEN-1:1]};
`endif

    // Final sign fix-up and result select, applied on the last iteration edge
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, final_res;

    assign prod_s    = neg_q ? -{iter_hi, iter_lo} : {iter_hi, iter_lo};
    assign quo_s     = neg_q ? -iter_lo : iter_lo;
    assign rem_s     = rem_neg_q ? -iter_hi : iter_hi;
    assign final_res = op_q[2] ? (op_q[1] ? rem_s : quo_s)
                               : ((op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        m_d       = m_q;
        op_d      = op_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        result_d  = result_q;
        unique case (state_q)
            IDLE: begin
                if (MulDivE && !FlushE) begin
                    op_d      = funct3E;
                    count_d   = '0;
                    neg_d     = sign_a ^ sign_b;
                    rem_neg_d = sign_a;
                    hi_d      = '0;
                    m_d       = funct3E[2] ? abs_b : abs_a;
                    lo_d      = funct3E[2] ? abs_a : abs_b;
                    state_d   = CALC;
                    if (div_zero) begin
                        result_d = funct3E[1] ? SrcAE : '1;
                        state_d  = DONE;
                    end else if (div_ovf) begin
                        result_d = funct3E[1] ? '0 : INT_MIN;
                        state_d  = DONE;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (!funct3E[2]) begin
                        result_d = fast_res;
                        state_d  = DONE;
                    end
`endif
                end
            end
            CALC: begin
                hi_d    = iter_hi;
                lo_d    = iter_lo;
                count_d = count_q + 5'd1;
                if (count_q == LAST) begin
                    result_d = final_res;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A flushed operation never publishes a result
        if (FlushE) begin
            state_d  = IDLE;
            count_d  = '0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            m_q       <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            m_q       <= m_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            result_q  <= result_d;
        end
    end

    assign StallMD  = ~reset & (((state_q == IDLE) & MulDivE & ~FlushE) | (state_q == CALC));
    assign DoneMD   = (state_q == DONE);
    assign ResultMD = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed vector table, flush/reset sequences,
// and randomized operations checked against a plain-arithmetic RV32M model.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        MulDivE;
    logic [2:0]  funct3E;
    logic [31:0] SrcAE, SrcBE;
    logic        FlushE;
    logic        StallMD, DoneMD;
    logic [31:0] ResultMD;

    int tests = 0;
    int fails = 0;
    logic [31:0] last_res = 32'h0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .MulDivE (MulDivE),
        .funct3E (funct3E),
        .SrcAE   (SrcAE),
        .SrcBE   (SrcBE),
        .FlushE  (FlushE),
        .StallMD (StallMD),
        .DoneMD  (DoneMD),
        .ResultMD(ResultMD)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string name, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        vec_t v;
        v.name = name; v.f3 = f3; v.a = a; v.b = b; v.exp_res = exp_res; v.exp_lat = exp_lat;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model straight from the RV32M definitions
    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (f3)
            3'b000: begin p = ua * ub; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
            3'b101: begin if (b == 0) return 32'hFFFFFFFF; p = ua / ub; return p[31:0]; end
            3'b110: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return MUL_LAT;
        if (b == 0) return 1;
        if (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return 33;
    endfunction

    // Issue one M instruction starting at posedge+1 and follow it to DoneMD
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int  cyc = 0;
        int  stall_cnt = 0;
        bit  done = 0;
        MulDivE = 1'b1; funct3E = f3; SrcAE = a; SrcBE = b;
        while (!done && cyc < 100) begin
            @(negedge clk);
            if (StallMD) stall_cnt++;
            if (DoneMD) done = 1;
            else begin @(posedge clk); #1; cyc++; end
        end
        check({name, " done-cycle"}, 32'(done ? cyc : -1), 32'(exp_lat));
        check({name, " stall-cycles"}, 32'(stall_cnt), 32'(exp_lat));
        check({name, " result"}, ResultMD, exp_res);
        $display("[TB] %-12s f3=%0d a=%h b=%h -> result=%h done@%0d stalls=%0d", name, f3, a, b,
                 ResultMD, cyc, stall_cnt);
        last_res = exp_res;
        @(posedge clk); #1;
        MulDivE = 1'b0;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int done_seen;
        reset = 1'b1; MulDivE = 1'b0; funct3E = 3'b0; SrcAE = '0; SrcBE = '0; FlushE = 1'b0;
        #2;
        check("reset StallMD", {31'b0, StallMD}, 32'h0);
        check("reset DoneMD", {31'b0, DoneMD}, 32'h0);
        check("reset ResultMD", ResultMD, 32'h0);
        #20;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        add_vec("MUL",       3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT);
        add_vec("MULH",      3'b001, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT);
        add_vec("MULHU",     3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
        add_vec("MULHSU",    3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, MUL_LAT);
        add_vec("DIV",       3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
        add_vec("REM",       3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
        add_vec("DIVU",      3'b101, 32'd100,      32'd7,        32'd14,       33);
        add_vec("REMU",      3'b111, 32'd100,      32'd7,        32'd2,        33);
        add_vec("DIVU/0",    3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        add_vec("REM/0",     3'b110, 32'd5,        32'd0,        32'd5,        1);
        add_vec("REMU/0",    3'b111, 32'd5,        32'd0,        32'd5,        1);
        add_vec("DIV-ovf",   3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        add_vec("REM-ovf",   3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1);
        add_vec("DIV-min/1", 3'b100, 32'h80000000, 32'd1,        32'h80000000, 33);
        add_vec("MUL3x5",    3'b000, 32'd3,        32'd5,        32'd15,       MUL_LAT);

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_lat);

        // Flush while iterating at count=10 (cycle 11)
        MulDivE = 1'b1; funct3E = 3'b101; SrcAE = 32'd1000; SrcBE = 32'd3;
        repeat (11) begin @(posedge clk); #1; end
        FlushE = 1'b1;
        @(negedge clk);
        check("flush-cycle StallMD", {31'b0, StallMD}, 32'h1);
        @(posedge clk); #1;
        FlushE = 1'b0; MulDivE = 1'b0;
        @(negedge clk);
        check("post-flush StallMD", {31'b0, StallMD}, 32'h0);
        check("post-flush DoneMD", {31'b0, DoneMD}, 32'h0);
        check("post-flush ResultMD", ResultMD, last_res);
        done_seen = 0;
        repeat (40) begin @(negedge clk); if (DoneMD) done_seen++; end
        check("flush no DoneMD", 32'(done_seen), 32'h0);
        check("held ResultMD", ResultMD, last_res);
        $display("[TB] FLUSH at count=10 -> result held %h", ResultMD);
        @(posedge clk); #1;
        run_op("DIVU-after", 3'b101, 32'd9, 32'd3, 32'd3, 33);

        // Randomized operations against the model
        for (int n = 0; n < 30; n++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            f3 = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            run_op("random", f3, a, b, ref_res(f3, a, b), ref_lat(f3, a, b));
        end

        // Asynchronous reset in the middle of an iteration
        MulDivE = 1'b1; funct3E = 3'b111; SrcAE = 32'd12345; SrcBE = 32'd7;
        repeat (5) begin @(posedge clk); #1; end
        #2;
        reset = 1'b1;
        #1;
        check("mid-reset StallMD", {31'b0, StallMD}, 32'h0);
        check("mid-reset DoneMD", {31'b0, DoneMD}, 32'h0);
        check("mid-reset ResultMD", ResultMD, 32'h0);
        $display("[TB] RESET mid-CALC -> stall=%b done=%b result=%h", StallMD, DoneMD, ResultMD);
        @(posedge clk); #1;
        reset = 1'b0; MulDivE = 1'b0;
        @(posedge clk); #1;
        run_op("REMU-after", 3'b111, 32'd12345, 32'd7, 32'd4, 33);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative RV32M multiply/divide unit in the Execute stage. It consumes operands and funct3 from the ID/EX pipeline registers. It holds the F/D/E stages with a stall request while the operation runs. It presents a registered 32-bit result for the Execute result mux in the cycle the stall releases. Division is radix-2 restoring, one quotient bit per cycle. Multiplication is shift-add by default, or single-cycle when configured.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- MulDivE  in  1  an M-extension instruction occupies Execute.
- funct3E  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcAE  in  32  rs1 operand, already forwarded.
- SrcBE  in  32  rs2 operand, already forwarded.
- FlushE  in  1  kill the operation in Execute.
- StallMD  out  1  hold F/D/E pipeline registers; combinational.
- DoneMD  out  1  ResultMD valid this cycle; registered state decode.
- ResultMD  out  32  operation result; registered, held between operations.

## Operation
- FSM states: IDLE, CALC, DONE.
- **IDLE**
  - If MulDivE=1 and FlushE=0, the unit captures the operands at the edge.
  - Captured values: |A|, |B| per signedness, result sign, op, count=0.
  - Next state is CALC, or DONE for special or fast cases.
- **CALC**
  - One iteration per cycle; count increments 0..31.
  - At count=31 the next state is DONE and the final sign/select is applied into ResultMD on that edge.
- **DONE**
  - DoneMD=1 and StallMD=0.
  - Next state is IDLE unconditionally. MulDivE is not re-sampled in DONE, because it still belongs to the same instruction.
- **StallMD** = (IDLE & MulDivE & ~FlushE) | CALC. It is forced to 0 while reset is high.
- **Signedness**
  - MULH, DIV, REM: both operands signed.
  - MULHSU: A signed, B unsigned.
  - Others: unsigned.
- **Result select**
  - MUL: low 32 bits of the 64-bit product.
  - MULH/MULHSU/MULHU: high 32 bits of the product.
  - DIV/DIVU: quotient. REM/REMU: remainder.
- **Sign rules**
  - Product is negated when the operand signs differ.
  - Quotient is negated when the signs differ.
  - Remainder takes the dividend's sign.
- **Special cases** are detected in IDLE and go directly to DONE with the result loaded at the start edge:
  - Divide by zero: quotient 0xFFFFFFFF; remainder = SrcAE.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- **FlushE**
  - In any state, FlushE=1 returns the FSM to IDLE at the next edge.
  - No DoneMD; ResultMD is unchanged.
  - FlushE takes priority over MulDivE.
- **Reset**
  - Asynchronous; valid mid-operation.
  - state=IDLE, count=0, ResultMD=0, DoneMD=0, all datapath registers 0.

## Timing
- Cycle 0 is the first cycle MulDivE=1 in IDLE.
- **Iterative operation**
  - StallMD is high in cycles 0..32; DONE is cycle 33.
  - The instruction spends 34 cycles in Execute.
- **Special case or fast multiply**
  - StallMD is high in cycle 0 only; DONE is cycle 1.
- ResultMD is stable from the DONE cycle until the next completed operation.
- Back-to-back M instructions: the second instruction's cycle 0 is the cycle after DONE.

## Configuration
- MULDIV_FAST_MUL_EN
  - **Defined:** MUL/MULH/MULHSU/MULHU compute a full 33x33 signed product combinationally and register it at the start edge, going IDLE→DONE with a 1-cycle stall. The shift-add multiply datapath is removed.
  - **Undefined:** multiplies use the 32-iteration shift-add path with the same timing as division.
  - Division behaviour is identical in both builds.

## Test plan
- MUL, A=7, B=0xFFFFFFFD (default build):
  - StallMD high 33 cycles.
  - DoneMD in cycle 33 with ResultMD=0xFFFFFFEB.
- High-half multiplies:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0x00000002 → 0xFFFFFFFF.
- Division and remainder:
  - DIV 0xFFFFFFF9/2 → 0xFFFFFFFD.
  - REM 0xFFFFFFF9/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
- Special cases (each: DoneMD in cycle 1, StallMD high in cycle 0 only):
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM with the same operands → 0.
- FlushE during CALC:
  - Assert FlushE in CALC at count=10 → IDLE next cycle, StallMD low, no DoneMD, ResultMD unchanged.
  - A following DIVU 9/3 → 3 at cycle 33.
- Reset and fast build:
  - Assert reset mid-CALC → StallMD, DoneMD and ResultMD go 0 without waiting for a clock edge.
  - With MULDIV_FAST_MUL_EN defined: MUL 3×5 → DoneMD cycle 1, ResultMD=15.
